// File: rtl/perf_pkg.sv
// Shared defaults and channel indices for the performance counter bank.
// The CPU top uses the channel enum to wire its run-statistic strobes.
package perf_pkg;

    localparam int unsigned DEF_NUM_CH = 4;
    localparam int unsigned DEF_CNT_W  = 32;

    typedef enum int unsigned {
        CH_TOTAL      = 0,
        CH_UNCOND     = 1,
        CH_COND       = 2,
        CH_COND_TAKEN = 3
    } perf_ch_e;

    // A single-channel bank still needs a 1-bit select port.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/perf_counter.sv
// One event-counter channel: live count, snapshot shadow and sticky overflow.
// Wrap or saturate behaviour is chosen per cycle by sat_mode.
module perf_counter
    import perf_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic             snap,
    input  logic             sat_mode,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] shadow,
    output logic             ovf
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             ovf_q, ovf_d;
    logic             at_max;

    assign at_max = &cnt_q;

    always_comb begin
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        ovf_d    = ovf_q;
        if (clr) begin
            cnt_d    = '0;
            shadow_d = '0;
            ovf_d    = 1'b0;
        end else begin
            // Shadow takes the registered value, so a same-cycle increment is not included.
            if (snap) begin
                shadow_d = cnt_q;
            end
            if (inc) begin
                if (at_max) begin
                    ovf_d = 1'b1;
                    if (!sat_mode) begin
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign cnt    = cnt_q;
    assign shadow = shadow_q;
    assign ovf    = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters with shared clear/snapshot control and a
// muxed readout feeding the display selector.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned SEL_W  = sel_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              clr,
    input  logic [NUM_CH-1:0] ev,
    input  logic [NUM_CH-1:0] en_mask,
    input  logic              sat_mode,
    input  logic              snap,
    input  logic              rd_shadow,
    input  logic [SEL_W-1:0]  sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] ovf,
    output logic              snap_valid
);

    logic [NUM_CH-1:0] inc;
    logic [CNT_W-1:0]  cnt_arr    [NUM_CH];
    logic [CNT_W-1:0]  shadow_arr [NUM_CH];
    logic              snap_valid_q, snap_valid_d;

    // halt only freezes counting; clr must also win over increments.
    always_comb begin
        inc = ev & en_mask & {NUM_CH{~halt & ~clr}};
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        perf_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc     (inc[i]),
            .clr     (clr),
            .snap    (snap),
            .sat_mode(sat_mode),
            .cnt     (cnt_arr[i]),
            .shadow  (shadow_arr[i]),
            .ovf     (ovf[i])
        );
    end

    always_comb begin
        snap_valid_d = snap_valid_q;
        if (clr) begin
            snap_valid_d = 1'b0;
        end else if (snap) begin
            snap_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_valid_q <= 1'b0;
        end else begin
            snap_valid_q <= snap_valid_d;
        end
    end

    assign snap_valid = snap_valid_q;

    // Out-of-range selects fall through to zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i)) begin
                rd_data = rd_shadow ? shadow_arr[i] : cnt_arr[i];
            end
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: vector table plus hand-written
// sequences for reset, wrap, saturate, gating, snapshot and clear priority.
module tb_perf_counter_bank;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned SEL_W  = 3;

    logic              clk;
    logic              rst;
    logic              halt;
    logic              clr;
    logic [NUM_CH-1:0] ev;
    logic [NUM_CH-1:0] en_mask;
    logic              sat_mode;
    logic              snap;
    logic              rd_shadow;
    logic [SEL_W-1:0]  sel;
    logic [CNT_W-1:0]  rd_data;
    logic [NUM_CH-1:0] ovf;
    logic              snap_valid;

    int n_total;
    int n_pass;

    perf_counter_bank #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W),
        .SEL_W (SEL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .halt      (halt),
        .clr       (clr),
        .ev        (ev),
        .en_mask   (en_mask),
        .sat_mode  (sat_mode),
        .snap      (snap),
        .rd_shadow (rd_shadow),
        .sel       (sel),
        .rd_data   (rd_data),
        .ovf       (ovf),
        .snap_valid(snap_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ev;
        logic [3:0] en;
        logic       halt;
        logic       clr;
        logic       sat;
        logic       snap;
        logic       rd_sh;
        logic [2:0] sel;
        logic [7:0] exp_rd;
        logic [3:0] exp_ovf;
        logic       exp_sv;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            ev = 4'(1 << ch);
            step();
        end
        ev = '0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic read_live(input int ch, input string name, input int exp);
        rd_shadow = 1'b0;
        sel       = 3'(ch);
        #1;
        check(name, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        rst       = 1'b0;
        halt      = 1'b0;
        clr       = 1'b0;
        ev        = '0;
        en_mask   = 4'b1111;
        sat_mode  = 1'b0;
        snap      = 1'b0;
        rd_shadow = 1'b0;
        sel       = '0;

        // Reset state
        #12;
        check("reset_rd", 32'(rd_data), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        check("reset_snap_valid", 32'(snap_valid), 32'd0);
        step();
        rst = 1'b1;
        pulse(0, 3);
        read_live(0, "precount_ch0", 3);

        // Asynchronous reset mid-count, no clock edge needed
        ev = 4'b0001;
        #2;
        rst = 1'b0;
        #1;
        check("midreset_rd", 32'(rd_data), 32'd0);
        ev = '0;
        step();
        rst = 1'b1;
        pulse(0, 5);
        read_live(0, "basic_ch0", 5);
        read_live(1, "basic_ch1", 0);
        read_live(2, "basic_ch2", 0);
        read_live(3, "basic_ch3", 0);

        // Wrap
        do_clr();
        pulse(1, 257);
        read_live(1, "wrap_ch1", 1);
        check("wrap_ovf", 32'(ovf), 32'b0010);

        // Saturate
        sat_mode = 1'b1;
        pulse(2, 300);
        read_live(2, "sat_ch2", 255);
        check("sat_ovf", 32'(ovf), 32'b0110);
        pulse(2, 5);
        read_live(2, "sat_hold_ch2", 255);
        sat_mode = 1'b0;

        // Gating
        halt = 1'b1;
        pulse(3, 10);
        read_live(3, "halt_ch3", 0);
        halt    = 1'b0;
        en_mask = 4'b0111;
        pulse(3, 10);
        read_live(3, "mask_ch3", 0);
        en_mask = 4'b1111;
        pulse(3, 3);
        read_live(3, "ungated_ch3", 3);

        // Snapshot with same-cycle increment
        do_clr();
        pulse(0, 7);
        snap = 1'b1;
        ev   = 4'b0001;
        step();
        snap = 1'b0;
        ev   = '0;
        rd_shadow = 1'b1;
        sel       = 3'd0;
        #1;
        check("snap_shadow_ch0", 32'(rd_data), 32'd7);
        check("snap_valid_set", 32'(snap_valid), 32'd1);
        read_live(0, "snap_live_ch0", 8);

        // Clear priority over snap and events
        sel = 3'd4;
        #1;
        check("sel_oob_live", 32'(rd_data), 32'd0);
        clr  = 1'b1;
        snap = 1'b1;
        ev   = 4'b1111;
        step();
        clr  = 1'b0;
        snap = 1'b0;
        ev   = '0;
        read_live(0, "clr_live_ch0", 0);
        rd_shadow = 1'b1;
        sel       = 3'd0;
        #1;
        check("clr_shadow_ch0", 32'(rd_data), 32'd0);
        check("clr_ovf", 32'(ovf), 32'd0);
        check("clr_snap_valid", 32'(snap_valid), 32'd0);

        // Vector table, starting from a cleared bank
        vecs[0] = '{4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd1, 4'b0000, 1'b0};
        vecs[1] = '{4'b0011, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'd1, 4'b0000, 1'b0};
        vecs[2] = '{4'b0100, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'd1, 4'b0000, 1'b0};
        vecs[3] = '{4'b1000, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 8'd2, 4'b0000, 1'b1};
        vecs[4] = '{4'b0001, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'd2, 4'b0000, 1'b1};
        vecs[5] = '{4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'd3, 4'b0000, 1'b1};
        vecs[6] = '{4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 8'd0, 4'b0000, 1'b1};
        vecs[7] = '{4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 8'd0, 4'b0000, 1'b1};
        vecs[8] = '{4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 4'b0000, 1'b0};
        vecs[9] = '{4'b0010, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'd1, 4'b0000, 1'b0};

        do_clr();
        for (int v = 0; v < 10; v++) begin
            ev        = vecs[v].ev;
            en_mask   = vecs[v].en;
            halt      = vecs[v].halt;
            clr       = vecs[v].clr;
            sat_mode  = vecs[v].sat;
            snap      = vecs[v].snap;
            rd_shadow = vecs[v].rd_sh;
            sel       = vecs[v].sel;
            step();
            check($sformatf("vec%0d_rd", v), 32'(rd_data), 32'(vecs[v].exp_rd));
            check($sformatf("vec%0d_ovf", v), 32'(ovf), 32'(vecs[v].exp_ovf));
            check($sformatf("vec%0d_sv", v), 32'(snap_valid), 32'(vecs[v].exp_sv));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
